// File: rtl/mrna_iso_pkg.sv
// -----------------------------------------------------------------------------
// mrna_iso_pkg
// Shared definitions for the mRNA-isolation array sequencer:
//   - state_e           : 4-bit protocol state encoding (IDLE = 0 ... DONE = 8)
//   - PUMP_PATTERN      : 6-phase peristaltic pattern {pump_1, pump_2, pump_3}
//   - OPEN_*            : per-state masks of valves driven open (0 on the line)
//   - valve_open_mask() : state -> open mask lookup
//   - pump_phase_pattern(), is_mix_state() : small decode helpers
// Valve mask bit order (MSB..LSB):
//   cells_in, cells_out, lysis_in, lysis_waste, beads_in, bead_waste,
//   push, sep, sieve, waste, collect
// -----------------------------------------------------------------------------
package mrna_iso_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_FILL_CELLS = 4'd1,
    ST_FILL_LYSIS = 4'd2,
    ST_MIX_LYSIS  = 4'd3,
    ST_FILL_BEADS = 4'd4,
    ST_MIX_BEADS  = 4'd5,
    ST_SEPARATE   = 4'd6,
    ST_COLLECT    = 4'd7,
    ST_DONE       = 4'd8
  } state_e;

  localparam int VALVE_N = 11;

  // Entry [0] is the first phase after a mix-state entry (110).
  localparam logic [5:0][2:0] PUMP_PATTERN = {
    3'b010, 3'b011, 3'b001, 3'b101, 3'b100, 3'b110
  };

  localparam logic [2:0] PUMP_ALL_CLOSED = 3'b111;

  localparam logic [VALVE_N-1:0] OPEN_NONE       = 11'b000_0000_0000;
  localparam logic [VALVE_N-1:0] OPEN_FILL_CELLS = 11'b110_0000_0000;
  localparam logic [VALVE_N-1:0] OPEN_FILL_LYSIS = 11'b001_1000_0000;
  localparam logic [VALVE_N-1:0] OPEN_MIX        = 11'b000_0000_1000;
  localparam logic [VALVE_N-1:0] OPEN_FILL_BEADS = 11'b000_0110_0000;
  // Sieve stays closed while separating so beads are held back from waste.
  localparam logic [VALVE_N-1:0] OPEN_SEPARATE   = 11'b000_0001_0010;
  localparam logic [VALVE_N-1:0] OPEN_COLLECT    = 11'b000_0001_0101;

  function automatic logic [VALVE_N-1:0] valve_open_mask(input state_e st);
    logic [VALVE_N-1:0] m;
    case (st)
      ST_FILL_CELLS: m = OPEN_FILL_CELLS;
      ST_FILL_LYSIS: m = OPEN_FILL_LYSIS;
      ST_MIX_LYSIS:  m = OPEN_MIX;
      ST_FILL_BEADS: m = OPEN_FILL_BEADS;
      ST_MIX_BEADS:  m = OPEN_MIX;
      ST_SEPARATE:   m = OPEN_SEPARATE;
      ST_COLLECT:    m = OPEN_COLLECT;
      default:       m = OPEN_NONE;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] pump_phase_pattern(input logic [2:0] idx);
    logic [2:0] p;
    case (idx)
      3'd0:    p = PUMP_PATTERN[0];
      3'd1:    p = PUMP_PATTERN[1];
      3'd2:    p = PUMP_PATTERN[2];
      3'd3:    p = PUMP_PATTERN[3];
      3'd4:    p = PUMP_PATTERN[4];
      3'd5:    p = PUMP_PATTERN[5];
      default: p = PUMP_ALL_CLOSED;
    endcase
    return p;
  endfunction

  function automatic logic is_mix_state(input state_e st);
    return (st == ST_MIX_LYSIS) || (st == ST_MIX_BEADS);
  endfunction

endpackage

// File: rtl/peristaltic_pump_driver.sv
// -----------------------------------------------------------------------------
// peristaltic_pump_driver
// Steps the three pump valves through the 6-phase peristaltic pattern, holding
// each phase PUMP_PHASE_CYC cycles, for rot_cnt full rotations.
// Inputs are next-cycle qualifiers so the pump lines can be registered and
// still line up with the sequencer's registered state:
//   clk, rst        : clock, synchronous active-high reset
//   enable          : pump runs in the coming cycle
//   restart         : coming cycle is the first of a mix step (phase 0)
//   hold            : freeze counters and outputs (pause)
//   rot_cnt         : rotations to run (non-zero whenever restart is given)
//   pump_1..pump_3  : registered pump valve lines, 1 = closed
//   rot_done        : high during the last cycle of the final rotation
// -----------------------------------------------------------------------------
module peristaltic_pump_driver
  import mrna_iso_pkg::*;
#(
  parameter int PUMP_PHASE_CYC = 64,
  parameter int ROT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             restart,
  input  logic             hold,
  input  logic [ROT_W-1:0] rot_cnt,
  output logic             pump_1,
  output logic             pump_2,
  output logic             pump_3,
  output logic             rot_done
);

  localparam int PH_W = (PUMP_PHASE_CYC > 1) ? $clog2(PUMP_PHASE_CYC) : 1;
  localparam logic [PH_W-1:0] PH_LOAD = PH_W'(PUMP_PHASE_CYC - 1);

  logic             active_r;
  logic [2:0]       phase_idx_r;
  logic [PH_W-1:0]  phase_cnt_r;
  logic [ROT_W-1:0] rot_left_r;   // rotations still to run after the current one
  logic [2:0]       pump_r;

  assign rot_done = active_r && (phase_idx_r == 3'd5) &&
                    (phase_cnt_r == {PH_W{1'b0}}) && (rot_left_r == {ROT_W{1'b0}});

  assign pump_1 = pump_r[2];
  assign pump_2 = pump_r[1];
  assign pump_3 = pump_r[0];

  // Phase/rotation counters and registered pump lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_r    <= 1'b0;
      phase_idx_r <= 3'd0;
      phase_cnt_r <= {PH_W{1'b0}};
      rot_left_r  <= {ROT_W{1'b0}};
      pump_r      <= PUMP_ALL_CLOSED;
    end else if (hold) begin
      active_r    <= active_r;
      phase_idx_r <= phase_idx_r;
      phase_cnt_r <= phase_cnt_r;
      rot_left_r  <= rot_left_r;
      pump_r      <= pump_r;
    end else if (restart) begin
      active_r    <= 1'b1;
      phase_idx_r <= 3'd0;
      phase_cnt_r <= PH_LOAD;
      rot_left_r  <= rot_cnt - 1'b1;
      pump_r      <= pump_phase_pattern(3'd0);
    end else if (enable) begin
      active_r <= 1'b1;
      if (phase_cnt_r == {PH_W{1'b0}}) begin
        phase_cnt_r <= PH_LOAD;
        if (phase_idx_r == 3'd5) begin
          phase_idx_r <= 3'd0;
          rot_left_r  <= rot_left_r - 1'b1;
          pump_r      <= pump_phase_pattern(3'd0);
        end else begin
          phase_idx_r <= phase_idx_r + 3'd1;
          pump_r      <= pump_phase_pattern(phase_idx_r + 3'd1);
        end
      end else begin
        phase_cnt_r <= phase_cnt_r - 1'b1;
      end
    end else begin
      active_r    <= 1'b0;
      phase_idx_r <= 3'd0;
      phase_cnt_r <= {PH_W{1'b0}};
      rot_left_r  <= {ROT_W{1'b0}};
      pump_r      <= PUMP_ALL_CLOSED;
    end
  end

endmodule

// File: rtl/mrna_iso_sequencer.sv
// -----------------------------------------------------------------------------
// mrna_iso_sequencer
// Protocol sequencer for the shared pneumatic lines of an mRNA-isolation array:
// fill cells, fill lysis, mix, fill beads, mix, separate, collect, done.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   start            : begin a protocol (sampled only in IDLE)
//   abort            : return to IDLE from any non-IDLE state
//   pause            : (MRNAISO_PAUSE_EN only) freeze the running protocol
//   mix_rot          : pump rotations per mix step, latched on accepted start
//   busy/done/aborted: status (done, aborted are one-cycle pulses)
//   step             : current state encoding (mrna_iso_pkg::state_e)
//   *_ctl, pump_1..3 : registered valve lines, 1 = pressurized/closed
// Optional feature macro: MRNAISO_PAUSE_EN adds the pause input.
// -----------------------------------------------------------------------------
module mrna_iso_sequencer
  import mrna_iso_pkg::*;
#(
  parameter int FILL_CYC       = 1024,
  parameter int PUMP_PHASE_CYC = 64,
  parameter int SEP_CYC        = 2048,
  parameter int COLLECT_CYC    = 1024,
  parameter int ROT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
`ifdef MRNAISO_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [ROT_W-1:0] mix_rot,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [3:0]       step,
  output logic             cells_in_ctl,
  output logic             cells_out_ctl,
  output logic             lysis_in_ctl,
  output logic             lysis_waste_ctl,
  output logic             beads_in_ctl,
  output logic             bead_waste_ctl,
  output logic             push_ctl,
  output logic             sep_ctl,
  output logic             sieve_ctl,
  output logic             waste_ctl,
  output logic             collect_ctl,
  output logic             pump_1,
  output logic             pump_2,
  output logic             pump_3
);

  localparam int MAX_A   = (FILL_CYC > SEP_CYC) ? FILL_CYC : SEP_CYC;
  localparam int MAX_CYC = (MAX_A > COLLECT_CYC) ? MAX_A : COLLECT_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_e               state_r;
  state_e               state_next_s;
  state_e               adv_state_s;
  logic [CNT_W-1:0]     step_cnt_r;
  logic [CNT_W-1:0]     step_cnt_next_s;
  logic [CNT_W-1:0]     adv_cnt_s;
  logic                 cnt_zero_s;
  logic [ROT_W-1:0]     mix_rot_r;
  logic                 accept_s;
  logic                 abort_take_s;
  logic                 hold_s;
  logic                 rot_done_s;
  logic                 pump_en_s;
  logic                 pump_restart_s;
  logic [VALVE_N-1:0]   valve_r;
  logic [VALVE_N-1:0]   valve_next_s;
  logic                 busy_r;
  logic                 busy_next_s;
  logic                 done_r;
  logic                 done_next_s;
  logic                 aborted_r;
  logic                 aborted_next_s;

  // Duration-1 loaded into the step counter on entry to a timed state.
  function automatic logic [CNT_W-1:0] step_load(input state_e st);
    logic [CNT_W-1:0] v;
    case (st)
      ST_FILL_CELLS, ST_FILL_LYSIS, ST_FILL_BEADS: v = CNT_W'(FILL_CYC - 1);
      ST_SEPARATE:                                 v = CNT_W'(SEP_CYC - 1);
      ST_COLLECT:                                  v = CNT_W'(COLLECT_CYC - 1);
      default:                                     v = {CNT_W{1'b0}};
    endcase
    return v;
  endfunction

  assign cnt_zero_s   = (step_cnt_r == {CNT_W{1'b0}});
  assign accept_s     = (state_r == ST_IDLE) && start && !abort;
  assign abort_take_s = abort && (state_r != ST_IDLE);

`ifdef MRNAISO_PAUSE_EN
  // Pause only freezes active protocol steps; abort overrides it.
  assign hold_s = pause && !abort_take_s &&
                  (state_r != ST_IDLE) && (state_r != ST_DONE);
`else
  assign hold_s = 1'b0;
`endif

  // Next-state and step-counter logic.
  always_comb begin
    adv_state_s = state_r;
    adv_cnt_s   = step_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) adv_state_s = ST_FILL_CELLS;
        else          adv_state_s = ST_IDLE;
      end
      ST_FILL_CELLS: begin
        if (cnt_zero_s) adv_state_s = ST_FILL_LYSIS;
        else            adv_cnt_s   = step_cnt_r - 1'b1;
      end
      ST_FILL_LYSIS: begin
        if (cnt_zero_s) adv_state_s = (mix_rot_r == {ROT_W{1'b0}}) ? ST_FILL_BEADS : ST_MIX_LYSIS;
        else            adv_cnt_s   = step_cnt_r - 1'b1;
      end
      ST_MIX_LYSIS: begin
        if (rot_done_s) adv_state_s = ST_FILL_BEADS;
        else            adv_state_s = ST_MIX_LYSIS;
      end
      ST_FILL_BEADS: begin
        if (cnt_zero_s) adv_state_s = (mix_rot_r == {ROT_W{1'b0}}) ? ST_SEPARATE : ST_MIX_BEADS;
        else            adv_cnt_s   = step_cnt_r - 1'b1;
      end
      ST_MIX_BEADS: begin
        if (rot_done_s) adv_state_s = ST_SEPARATE;
        else            adv_state_s = ST_MIX_BEADS;
      end
      ST_SEPARATE: begin
        if (cnt_zero_s) adv_state_s = ST_COLLECT;
        else            adv_cnt_s   = step_cnt_r - 1'b1;
      end
      ST_COLLECT: begin
        if (cnt_zero_s) adv_state_s = ST_DONE;
        else            adv_cnt_s   = step_cnt_r - 1'b1;
      end
      ST_DONE: adv_state_s = ST_IDLE;
      default: adv_state_s = ST_IDLE;
    endcase

    if (abort_take_s)  state_next_s = ST_IDLE;
    else if (hold_s)   state_next_s = state_r;
    else               state_next_s = adv_state_s;

    // Any state change reloads the counter; abort lands in IDLE and clears it.
    if (state_next_s != state_r) step_cnt_next_s = step_load(state_next_s);
    else if (hold_s)             step_cnt_next_s = step_cnt_r;
    else                         step_cnt_next_s = adv_cnt_s;
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    valve_next_s   = ~valve_open_mask(state_next_s);
    busy_next_s    = (state_next_s != ST_IDLE);
    done_next_s    = (state_next_s == ST_DONE);
    aborted_next_s = abort_take_s;
    pump_en_s      = is_mix_state(state_next_s);
    pump_restart_s = pump_en_s && (state_next_s != state_r);
  end

  // State, counters, latched rotation count and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      step_cnt_r <= {CNT_W{1'b0}};
      mix_rot_r  <= {ROT_W{1'b0}};
      valve_r    <= {VALVE_N{1'b1}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      aborted_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      step_cnt_r <= step_cnt_next_s;
      mix_rot_r  <= accept_s ? mix_rot : mix_rot_r;
      valve_r    <= valve_next_s;
      busy_r     <= busy_next_s;
      done_r     <= done_next_s;
      aborted_r  <= aborted_next_s;
    end
  end

  peristaltic_pump_driver #(
    .PUMP_PHASE_CYC (PUMP_PHASE_CYC),
    .ROT_W          (ROT_W)
  ) u_pump (
    .clk      (clk),
    .rst      (rst),
    .enable   (pump_en_s),
    .restart  (pump_restart_s),
    .hold     (hold_s),
    .rot_cnt  (mix_rot_r),
    .pump_1   (pump_1),
    .pump_2   (pump_2),
    .pump_3   (pump_3),
    .rot_done (rot_done_s)
  );

  assign step            = state_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign aborted         = aborted_r;
  assign cells_in_ctl    = valve_r[10];
  assign cells_out_ctl   = valve_r[9];
  assign lysis_in_ctl    = valve_r[8];
  assign lysis_waste_ctl = valve_r[7];
  assign beads_in_ctl    = valve_r[6];
  assign bead_waste_ctl  = valve_r[5];
  assign push_ctl        = valve_r[4];
  assign sep_ctl         = valve_r[3];
  assign sieve_ctl       = valve_r[2];
  assign waste_ctl       = valve_r[1];
  assign collect_ctl     = valve_r[0];

endmodule

// File: tb/tb_mrna_iso_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mrna_iso_sequencer
// Self-checking bench for mrna_iso_sequencer with short step durations.
// The reference model lays the protocol out as a list of (state, length)
// segments and derives the expected outputs for any cycle arithmetically.
// -----------------------------------------------------------------------------
module tb_mrna_iso_sequencer;

  localparam int F  = 4;
  localparam int P  = 2;
  localparam int S  = 3;
  localparam int C  = 3;
  localparam int RW = 8;

  logic clk = 1'b0;
  logic rst, start, abort, pause;
  logic [RW-1:0] mix_rot;
  logic busy, done, aborted;
  logic [3:0] step;
  logic cells_in_ctl, cells_out_ctl, lysis_in_ctl, lysis_waste_ctl, beads_in_ctl;
  logic bead_waste_ctl, push_ctl, sep_ctl, sieve_ctl, waste_ctl, collect_ctl;
  logic pump_1, pump_2, pump_3;
  logic [13:0] obs_lines;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mrna_iso_sequencer #(
    .FILL_CYC(F), .PUMP_PHASE_CYC(P), .SEP_CYC(S), .COLLECT_CYC(C), .ROT_W(RW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
`ifdef MRNAISO_PAUSE_EN
    .pause(pause),
`endif
    .mix_rot(mix_rot), .busy(busy), .done(done), .aborted(aborted), .step(step),
    .cells_in_ctl(cells_in_ctl), .cells_out_ctl(cells_out_ctl),
    .lysis_in_ctl(lysis_in_ctl), .lysis_waste_ctl(lysis_waste_ctl),
    .beads_in_ctl(beads_in_ctl), .bead_waste_ctl(bead_waste_ctl),
    .push_ctl(push_ctl), .sep_ctl(sep_ctl), .sieve_ctl(sieve_ctl),
    .waste_ctl(waste_ctl), .collect_ctl(collect_ctl),
    .pump_1(pump_1), .pump_2(pump_2), .pump_3(pump_3)
  );

  assign obs_lines = {cells_in_ctl, cells_out_ctl, lysis_in_ctl, lysis_waste_ctl,
                      beads_in_ctl, bead_waste_ctl, push_ctl, sep_ctl, sieve_ctl,
                      waste_ctl, collect_ctl, pump_1, pump_2, pump_3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pump phases 0..5 as {pump_1, pump_2, pump_3}.
  function automatic logic [2:0] pump_pat(input int ph);
    case (ph)
      0: return 3'b110;
      1: return 3'b100;
      2: return 3'b101;
      3: return 3'b001;
      4: return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  // Closed-line vector for a state; off = cycles already spent in that state.
  function automatic logic [13:0] exp_lines(input int st, input int off);
    logic [13:0] v;
    v = 14'h3FFF;
    case (st)
      1: begin v[13] = 1'b0; v[12] = 1'b0; end
      2: begin v[11] = 1'b0; v[10] = 1'b0; end
      3, 5: begin v[6] = 1'b0; v[2:0] = pump_pat((off / P) % 6); end
      4: begin v[9] = 1'b0; v[8] = 1'b0; end
      6: begin v[7] = 1'b0; v[4] = 1'b0; end
      7: begin v[7] = 1'b0; v[5] = 1'b0; v[3] = 1'b0; end
      default: v = 14'h3FFF;
    endcase
    return v;
  endfunction

  function automatic int done_cycle(input int m);
    return 3 * F + 2 * m * 6 * P + S + C + 1;
  endfunction

  // State and offset at protocol cycle te (te = 1 is the first FILL_CELLS cycle).
  task automatic model_state(input int te, input int m, output int st, output int off);
    int lens[9];
    int cum;
    lens[0] = 0; lens[1] = F; lens[2] = F; lens[3] = m * 6 * P; lens[4] = F;
    lens[5] = m * 6 * P; lens[6] = S; lens[7] = C; lens[8] = 1;
    st = 0; off = 0; cum = 0;
    for (int s = 1; s <= 8; s++) begin
      if (te > cum && te <= cum + lens[s]) begin
        st = s; off = te - cum - 1;
      end
      cum += lens[s];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_aborted);
    check({tag, " step"}, 32'(step), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " aborted"}, 32'(aborted), 32'(exp_aborted));
    check({tag, " lines"}, 32'(obs_lines), 32'h3FFF);
  endtask

  // One protocol run; negative cycle numbers disable the optional events.
  task automatic run(input string name, input int m, input int start_again,
                     input int abort_at, input int rst_at, input int p0, input int p1);
    int t_done, total, pc, st, off, ab_st, ab_off;
    string tag;
    t_done = done_cycle(m);
    pc = (p0 >= 0) ? (p1 - p0 + 1) : 0;
    total = t_done + pc + 3;
    ab_st = 0;
    if (abort_at >= 0) model_state(abort_at, m, ab_st, ab_off);
    start = 1'b1; abort = 1'b0; rst = 1'b0; pause = 1'b0; mix_rot = RW'(m);
    check_idle($sformatf("%s t=0", name), 1'b0);
    for (int t = 1; t <= total; t++) begin
      tick();
      start = (t == start_again);
      if (t == start_again) mix_rot = RW'($urandom_range(1, 255));
      abort = (t == abort_at);
      rst   = (t == rst_at);
      pause = (t >= p0) && (t <= p1) && (p0 >= 0);
      tag = $sformatf("%s t=%0d", name, t);
      if (rst_at >= 0 && t > rst_at) begin
        check_idle(tag, 1'b0);
      end else if (abort_at >= 0 && t > abort_at) begin
        check_idle(tag, (t == abort_at + 1) && (ab_st != 0));
      end else begin
        // Paused cycles before t do not advance the protocol.
        int np;
        np = (p0 < 0 || t <= p0) ? 0 : (((t - 1 < p1) ? t - 1 : p1) - p0 + 1);
        model_state(t - np, m, st, off);
        check({tag, " step"}, 32'(step), 32'(st));
        check({tag, " busy"}, 32'(busy), 32'(st != 0));
        check({tag, " done"}, 32'(done), 32'(st == 8));
        check({tag, " aborted"}, 32'(aborted), 32'd0);
        check({tag, " lines"}, 32'(obs_lines), 32'(exp_lines(st, off)));
      end
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0; pause = 1'b0;
    tick();
  endtask

  initial begin
    int m, a, s, td;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0; mix_rot = '0;
    tick();
    tick();
    check_idle("reset", 1'b0);
    rst = 1'b0;
    tick();
    check_idle("post_reset", 1'b0);

    // Nominal run with an ignored start (and new mix_rot) at cycle 5.
    run("nominal", 1, 5, -1, -1, -1, -1);
    // Mix steps skipped.
    run("rot0", 0, 3, -1, -1, -1, -1);
    // Abort mid MIX_LYSIS.
    run("abort_mix", 1, 5, 15, -1, -1, -1);
    // Abort in DONE.
    run("abort_done", 1, -1, done_cycle(1), -1, -1, -1);
    // Reset mid-protocol.
    run("rst_mid", 1, -1, -1, 30, -1, -1);

    // start together with abort in IDLE: abort wins.
    start = 1'b1; abort = 1'b1; mix_rot = 8'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    check_idle("start_abort_idle c1", 1'b0);
    tick();
    check_idle("start_abort_idle c2", 1'b0);

    // Largest rotation count must run fully without wrapping.
    run("rot_max", 255, 100, -1, -1, -1, -1);

`ifdef MRNAISO_PAUSE_EN
    run("pause", 1, -1, -1, -1, 10, 14);
`endif

    // Randomized runs: rotation count, ignored start and abort point.
    for (int i = 0; i < 8; i++) begin
      m  = $urandom_range(0, 4);
      td = done_cycle(m);
      a  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, td) : -1;
      if (a < 0)      s = $urandom_range(1, td);
      else if (a > 1) s = $urandom_range(1, a - 1);
      else            s = -1;
      run($sformatf("rand%0d_m%0d", i, m), m, s, a, -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
